// File: rtl/pc_stage.sv
// pc_stage: holds the architectural PC, offers it to fetch, and computes the next PC on retire.
// Optional feature macro PC_PERF_CNT_EN adds 64-bit InstCnt/StallCnt performance counters.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pc_stage #(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int                     PCSRC_W  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   Iready,
  output logic                   Pvalid,
  output logic [`DATA_WIDTH-1:0] PC,
  input  logic                   Wvalid,
  output logic                   Pready,
  input  logic [PCSRC_W-1:0]     PCSrc,
  input  logic                   BranchTaken,
  input  logic [`DATA_WIDTH-1:0] Target,
  input  logic [`DATA_WIDTH-1:0] Mtvec,
  input  logic [`DATA_WIDTH-1:0] Mepc,
  input  logic                   Halt,
  output logic                   Halted,
  output logic                   PCerr
`ifdef PC_PERF_CNT_EN
  ,
  output logic [63:0]            InstCnt,
  output logic [63:0]            StallCnt
`endif
);

  localparam logic [PCSRC_W-1:0] SRC_BRANCH = PCSRC_W'(1);
  localparam logic [PCSRC_W-1:0] SRC_JAL    = PCSRC_W'(2);
  localparam logic [PCSRC_W-1:0] SRC_JALR   = PCSRC_W'(3);
  localparam logic [PCSRC_W-1:0] SRC_TRAP   = PCSRC_W'(4);
  localparam logic [PCSRC_W-1:0] SRC_MRET   = PCSRC_W'(5);

  typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HALT} state_t;

  state_t                 state;
  logic [`DATA_WIDTH-1:0] pcPlus4;
  logic [`DATA_WIDTH-1:0] nextPc;
  logic                   misaligned;
  logic                   retire;

  assign pcPlus4    = PC + `DATA_WIDTH'(4);
  assign misaligned = |nextPc[1:0];
  assign retire     = (state == WAIT) && Wvalid && Pready;

  // Unlisted select codes fall through to the sequential PC.
  always_comb begin
    nextPc = pcPlus4;
    case (PCSrc)
      SRC_BRANCH: if (BranchTaken) nextPc = Target;
      SRC_JAL:    nextPc = Target;
      SRC_JALR:   nextPc = Target & ~`DATA_WIDTH'(1);
      SRC_TRAP:   nextPc = Mtvec & ~`DATA_WIDTH'(3);
      SRC_MRET:   nextPc = Mepc;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= BOOT;
      PC     <= RESET_PC;
      Pvalid <= 1'b0;
      Pready <= 1'b0;
      Halted <= 1'b0;
      PCerr  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= ISSUE;
          Pvalid <= 1'b1;
        end
        ISSUE: begin
          if (Pvalid && Iready) begin
            state  <= WAIT;
            Pvalid <= 1'b0;
            Pready <= 1'b1;
          end
        end
        WAIT: begin
          if (retire) begin
            Pready <= 1'b0;
            // An ebreak takes priority over any misalignment of the would-be next PC.
            if (Halt) begin
              state  <= HALT;
              Halted <= 1'b1;
            end else if (misaligned) begin
              state  <= HALT;
              Halted <= 1'b1;
              PCerr  <= 1'b1;
            end else begin
              state  <= ISSUE;
              PC     <= nextPc;
              Pvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      InstCnt  <= 64'd0;
      StallCnt <= 64'd0;
    end else begin
      if (retire && !Halt)
        InstCnt <= InstCnt + 64'd1;
      if (state == ISSUE && !Iready)
        StallCnt <= StallCnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_stage.sv
// Scoreboard bench for pc_stage: a transaction-level PC model feeds expected fetch/halt queues.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_pc_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Iready = 1'b0;
  logic        Wvalid = 1'b0;
  logic        BranchTaken = 1'b0;
  logic        Halt = 1'b0;
  logic [2:0]  PCSrc = 3'd0;
  logic [31:0] Target = 32'd0;
  logic [31:0] Mtvec = 32'd0;
  logic [31:0] Mepc = 32'd0;
  logic        Pvalid, Pready, Halted, PCerr;
  logic [31:0] PC;
`ifdef PC_PERF_CNT_EN
  logic [63:0] InstCnt, StallCnt;
`endif

  pc_stage #(.RESET_PC(RESET_PC), .PCSRC_W(3)) dut (
    .clk(clk), .resetn(resetn), .Iready(Iready), .Pvalid(Pvalid), .PC(PC),
    .Wvalid(Wvalid), .Pready(Pready), .PCSrc(PCSrc), .BranchTaken(BranchTaken),
    .Target(Target), .Mtvec(Mtvec), .Mepc(Mepc), .Halt(Halt), .Halted(Halted),
    .PCerr(PCerr)
`ifdef PC_PERF_CNT_EN
    , .InstCnt(InstCnt), .StallCnt(StallCnt)
`endif
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  logic [31:0]     pcQ[$];
  logic [32:0]     haltQ[$];
  logic [31:0]     modelPc = RESET_PC;
  longint unsigned modelInst = 0;
  longint unsigned modelStall = 0;
  logic            prevHalted = 1'b0;
  logic [32:0]     haltExp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at time %0t", name, $time);
  endtask

  function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [2:0] src,
                                            input logic taken, input logic [31:0] tgt,
                                            input logic [31:0] mtv, input logic [31:0] mep);
    case (src)
      3'd1:    return taken ? tgt : pc + 32'd4;
      3'd2:    return tgt;
      3'd3:    return {tgt[31:1], 1'b0};
      3'd4:    return {mtv[31:2], 2'b00};
      3'd5:    return mep;
      default: return pc + 32'd4;
    endcase
  endfunction

  // Monitor: every fetch handshake and every halt entry is checked against the scoreboard.
  always @(negedge clk) begin
    if (resetn && Pvalid && Iready) begin
      if (pcQ.size() == 0) failNow("unexpectedFetch");
      else checkOutput("fetchPc", 64'(PC), 64'(pcQ.pop_front()));
    end
    if (Halted && !prevHalted) begin
      if (haltQ.size() == 0) failNow("unexpectedHalt");
      else begin
        haltExp = haltQ.pop_front();
        checkOutput("haltPcerr", 64'(PCerr), 64'(haltExp[32]));
        checkOutput("haltPc", 64'(PC), 64'(haltExp[31:0]));
      end
    end
    prevHalted = Halted;
  end

  task automatic doReset();
    pcQ.delete();
    haltQ.delete();
    Iready = 1'b0;
    Wvalid = 1'b0;
    Halt   = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("resetPc", 64'(PC), 64'(RESET_PC));
    checkOutput("resetPvalid", 64'(Pvalid), 64'd0);
    checkOutput("resetPready", 64'(Pready), 64'd0);
    checkOutput("resetHalted", 64'(Halted), 64'd0);
    checkOutput("resetPcerr", 64'(PCerr), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("bootPvalid", 64'(Pvalid), 64'd0);
    @(posedge clk); #1;
    modelPc    = RESET_PC;
    modelInst  = 0;
    modelStall = 0;
    pcQ.push_back(RESET_PC);
  endtask

  task automatic doFetch(input int stall);
    int n;
    for (int i = 0; i < stall; i++) begin
      Iready = 1'b0;
      Wvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("stallPvalid", 64'(Pvalid), 64'd1);
      checkOutput("stallPc", 64'(PC), 64'(modelPc));
      @(posedge clk); #1;
      modelStall++;
    end
    Wvalid = 1'b0;
    Iready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!Pvalid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!Pvalid) failNow("fetchTimeout");
    @(posedge clk); #1;
    Iready = 1'b0;
  endtask

  task automatic doRetire(input int waitCyc, input logic [2:0] src, input logic taken,
                          input logic [31:0] tgt, input logic [31:0] mtv, input logic [31:0] mep,
                          input logic halt, output logic stopped);
    int n;
    logic [31:0] nxt;
    for (int i = 0; i < waitCyc; i++) begin
      Wvalid = 1'b0;
      Iready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("waitPready", 64'(Pready), 64'd1);
      checkOutput("waitPvalid", 64'(Pvalid), 64'd0);
      @(posedge clk); #1;
    end
    Iready = 1'b0;
    PCSrc = src; BranchTaken = taken; Target = tgt; Mtvec = mtv; Mepc = mep; Halt = halt;
    Wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!Pready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!Pready) failNow("retireTimeout");
    @(posedge clk); #1;
    Wvalid = 1'b0;
    Halt   = 1'b0;
    nxt = modelNext(modelPc, src, taken, tgt, mtv, mep);
    if (!halt) modelInst++;
    stopped = halt || (nxt[1:0] != 2'b00);
    if (stopped) begin
      haltQ.push_back({!halt, modelPc});
      for (int i = 0; i < 4; i++) begin
        Iready = 1'($urandom);
        Wvalid = 1'($urandom);
        @(negedge clk);
        checkOutput("haltedStay", 64'(Halted), 64'd1);
        checkOutput("haltPvalid", 64'(Pvalid), 64'd0);
        checkOutput("haltPready", 64'(Pready), 64'd0);
        @(posedge clk); #1;
      end
      Iready = 1'b0;
      Wvalid = 1'b0;
    end else begin
      modelPc = nxt;
      pcQ.push_back(nxt);
    end
  endtask

  task automatic applyStimulus(input int stall, input int waitCyc, input logic [2:0] src,
                               input logic taken, input logic [31:0] tgt, input logic [31:0] mtv,
                               input logic [31:0] mep, input logic halt, output logic stopped);
    doFetch(stall);
    doRetire(waitCyc, src, taken, tgt, mtv, mep, halt, stopped);
  endtask

  initial begin
    logic        st;
    logic [31:0] rt, rm;
    doReset();
    applyStimulus(5, 0, 3'd1, 1'b0, 32'h8000_0100, 32'd0, 32'd0, 1'b0, st);
`ifdef PC_PERF_CNT_EN
    checkOutput("stallCnt5", StallCnt, 64'd5);
`endif
    applyStimulus(0, 1, 3'd1, 1'b1, 32'h8000_0100, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(0, 0, 3'd3, 1'b0, 32'h8000_0021, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(2, 0, 3'd2, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(0, 2, 3'd0, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(1, 0, 3'd4, 1'b0, 32'd0, 32'h1234_5677, 32'd0, 1'b0, st);
    applyStimulus(0, 0, 3'd5, 1'b0, 32'd0, 32'd0, 32'h8000_0040, 1'b0, st);
    applyStimulus(0, 0, 3'd6, 1'b0, 32'h0000_0003, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(0, 1, 3'd7, 1'b0, 32'h0000_0003, 32'd0, 32'd0, 1'b0, st);
    applyStimulus(0, 0, 3'd2, 1'b0, 32'h8000_0022, 32'd0, 32'd0, 1'b0, st);
    doReset();
    doFetch(0);
    doReset();
    applyStimulus(0, 1, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, st);
    doReset();

    for (int k = 0; k < 200; k++) begin
      rt = $urandom;
      rm = $urandom;
      if ($urandom_range(0, 29) != 0) rt[1:0] = 2'b00;
      if ($urandom_range(0, 29) != 0) rm[1:0] = 2'b00;
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 1'($urandom), rt, $urandom, rm,
                    1'($urandom_range(0, 39) == 0), st);
      if (st) doReset();
    end

    doFetch(1);
`ifdef PC_PERF_CNT_EN
    checkOutput("instCnt", InstCnt, 64'(modelInst));
    checkOutput("stallCnt", StallCnt, 64'(modelStall));
`endif
    checkOutput("pcQueueDrained", 64'(pcQ.size()), 64'd0);
    checkOutput("haltQueueDrained", 64'(haltQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pc_stage.md
Name: pc_stage

Overview:
- Program-counter stage of the multi-cycle core; sits directly upstream of the instruction-fetch unit.
- Holds the architectural PC and offers it to fetch with a valid/ready handshake (Pvalid out, Iready in).
- Waits for the writeback stage to retire the instruction, then computes the next PC (sequential, branch, jump, trap, mret) and offers it.
- One instruction is in flight at a time.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- PCSRC_W, 3, width of the next-PC select field.

Ports:
- clk  input  1  core clock
- resetn  input  1  synchronous active-low reset
- Iready  input  1  fetch unit ready to accept a PC
- Pvalid  output  1  PC valid toward fetch
- PC  output  `DATA_WIDTH  current fetch address
- Wvalid  input  1  writeback has retired the in-flight instruction
- Pready  output  1  PC stage ready to accept the retire/redirect info
- PCSrc  input  PCSRC_W  next-PC select (encoding in Behaviour)
- BranchTaken  input  1  conditional branch resolved taken
- Target  input  `DATA_WIDTH  branch/jal/jalr target from execute
- Mtvec  input  `DATA_WIDTH  trap vector CSR
- Mepc  input  `DATA_WIDTH  exception PC CSR
- Halt  input  1  retired instruction is ebreak
- Halted  output  1  core stopped
- PCerr  output  1  misaligned next-PC detected

Behaviour:
- Single clock domain; all state changes on posedge clk.
- Reset is synchronous, active-low, and overrides everything, including mid-handshake.
- Reset values:
  - PC=RESET_PC, Pvalid=0, Pready=0, Halted=0, PCerr=0.
  - State=BOOT.
- States: BOOT, ISSUE, WAIT, HALT.
- BOOT: one cycle after reset release, then ISSUE with Pvalid=1.
- ISSUE: Pvalid=1, Pready=0.
  - PC and Pvalid are held stable until Iready=1 is sampled.
  - On Pvalid&&Iready: next cycle goes to WAIT with Pvalid=0 and Pready=1.
- WAIT: Pvalid=0, Pready=1.
  - On Wvalid&&Pready with Halt=1: go to HALT, Halted=1, PC held.
  - Otherwise on Wvalid&&Pready: register the next PC, go to ISSUE, Pvalid=1 on the following cycle.
- Latency: retire handshake at cycle N gives new PC with Pvalid=1 at cycle N+1.
- Next-PC select (PCSrc):
  - 0 = PC+4
  - 1 = BranchTaken ? Target : PC+4
  - 2 = Target
  - 3 = Target & ~32'h1
  - 4 = Mtvec & ~32'h3
  - 5 = Mepc
  - 6 and 7 = PC+4
- All adds are modulo 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
- Misalignment: if the selected next PC has bits[1:0]≠0, go to HALT with PCerr=1 and Halted=1; PC keeps the old value.
- HALT: absorbing until reset; Pvalid=0, Pready=0; Iready and Wvalid are ignored.
- Ignored inputs:
  - Wvalid outside WAIT (Pready=0) is ignored.
  - Iready outside ISSUE is ignored.
- Simultaneous Iready and Wvalid are impossible to act on in the same state and need no special handling.
- Reset asserted in any state returns to BOOT the next cycle with reset values.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- Defined:
  - Adds outputs InstCnt (64-bit) and StallCnt (64-bit), both reset to 0.
  - InstCnt increments on each non-halting Wvalid&&Pready.
  - StallCnt increments on each ISSUE cycle with Iready=0.
  - Both counters wrap at 2^64.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, Iready=1 → Pvalid=1 with PC=0x8000_0000 one cycle after BOOT; next cycle Pvalid=0, Pready=1.
- ISSUE with Iready held 0 for 5 cycles → PC=0x8000_0000 and Pvalid=1 stable all 5 cycles; handshake on cycle 6 → WAIT; StallCnt=5 when PC_PERF_CNT_EN is defined.
- WAIT, Wvalid=1:
  - PCSrc=1, BranchTaken=0, Target=0x8000_0100 → next PC 0x8000_0004.
  - Repeat with BranchTaken=1 → next PC 0x8000_0100.
- PCSrc=3, Target=0x8000_0021 → next PC 0x8000_0020.
- PCSrc=2, Target=0x8000_0022 → Halted=1, PCerr=1, PC unchanged, Pvalid stays 0.
- PC=0xFFFF_FFFC, PCSrc=0 retire → PC=0x0000_0000.
- Halt=1 retire → Halted=1 permanently; later Wvalid/Iready pulses ignored.
- resetn=0 while in WAIT → PC=RESET_PC, state BOOT, Pvalid=0.
